// File: rtl/tm_rsenc_ctrl_pkg.sv
// Shared constants and types for the TM CADU framer: ASM pattern, RS(255,223) lengths, FSM states.
package tm_pkg;
  localparam int unsigned ASM_LEN  = 4;
  localparam int unsigned DATA_LEN = 223;
  localparam int unsigned CODE_LEN = 255;
  localparam int unsigned CADU_LEN = ASM_LEN + CODE_LEN;

  localparam logic [7:0]  FILL_DEF = 8'h55;
  localparam logic [31:0] ASM_WORD = 32'h1ACF_FC1D;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ASM,
    ST_CODE
  } state_t;

  // ASM byte idx, most significant byte first on the wire
  function automatic logic [7:0] asm_byte(input logic [1:0] idx);
    logic [31:0] w;
    w = ASM_WORD >> {2'd3 - idx, 3'b000};
    return w[7:0];
  endfunction
endpackage

// File: rtl/tm_rsenc_ctrl_if.sv
// Source, encoder and downlink signals of the CADU framer; master is the framer, slave its environment.
interface tm_rsenc_ctrl_if;
  logic       TICK;
  logic       SRC_AVAIL;
  logic [7:0] SRC_DATA;
  logic       SRC_RD;
  logic       IDLE_EN;
  logic       ENC_START;
  logic       ENC_CLKEN;
  logic [7:0] ENC_DATA;
  logic       ENC_RFS;
  logic       ENC_RFD;
  logic       ENC_RDY;
  logic [7:0] ENC_CODE;
  logic [7:0] TX_DATA;
  logic       TX_VALID;
  logic       TX_SOF;
  logic       UNDERRUN;
  logic       ENC_ERR;
  logic [15:0] FRAME_CNT;

  modport master (
    input  TICK, SRC_AVAIL, SRC_DATA, IDLE_EN, ENC_RFS, ENC_RFD, ENC_RDY, ENC_CODE,
    output SRC_RD, ENC_START, ENC_CLKEN, ENC_DATA, TX_DATA, TX_VALID, TX_SOF,
           UNDERRUN, ENC_ERR, FRAME_CNT
  );

  modport slave (
    output TICK, SRC_AVAIL, SRC_DATA, IDLE_EN, ENC_RFS, ENC_RFD, ENC_RDY, ENC_CODE,
    input  SRC_RD, ENC_START, ENC_CLKEN, ENC_DATA, TX_DATA, TX_VALID, TX_SOF,
           UNDERRUN, ENC_ERR, FRAME_CNT
  );
endinterface

// File: rtl/tm_rsenc_ctrl.sv
// TM CADU framer: ASM + RS(255,223) codeword, one byte per TICK; TX byte registered 1 cycle after its TICK.
// No backpressure: the serializer TICK paces source pops, encoder feed and output alike.
module tm_rsenc_ctrl
  import tm_pkg::*;
#(
  parameter int unsigned ENC_LAT = 2,
  parameter logic [7:0]  FILL    = FILL_DEF
) (
  input  logic            CLK,
  input  logic            NGRST,
  input  logic            RST,
  tm_rsenc_ctrl_if.master bus
);
  localparam logic [8:0] FEED_FIRST = 9'(ASM_LEN - ENC_LAT);
  localparam logic [8:0] K_ASM_LAST = 9'(ASM_LEN - 1);
  localparam logic [8:0] K_LAST     = 9'(CADU_LEN - 1);

  state_t     state, state_nxt;
  logic [8:0] k;
  logic [8:0] feed_off;
  logic       data_frame;
  logic       active, frame_tick, last_tick, decide, go;
  logic       in_feed, enc_start, hs_fault;

  assign active     = (state != ST_IDLE);
  assign frame_tick = bus.TICK && active;
  assign last_tick  = frame_tick && (state == ST_CODE) && (k == K_LAST);
  assign decide     = (bus.TICK && (state == ST_IDLE)) || last_tick;
  assign go         = bus.SRC_AVAIL || bus.IDLE_EN;

  // k below FEED_FIRST wraps to a large offset and so falls outside the window
  assign feed_off  = k - FEED_FIRST;
  assign in_feed   = active && (feed_off < 9'(DATA_LEN));
  assign enc_start = bus.TICK && in_feed && (feed_off == 9'd0);
  assign hs_fault  = (enc_start && !bus.ENC_RFS)
                   || (in_feed && !bus.ENC_RFD)
                   || ((k >= 9'(ASM_LEN)) && !bus.ENC_RDY);

  assign bus.ENC_CLKEN = bus.TICK;
  assign bus.ENC_START = enc_start;
  assign bus.SRC_RD    = bus.TICK && in_feed && data_frame;
  assign bus.ENC_DATA  = !in_feed ? 8'h00 : (data_frame ? bus.SRC_DATA : FILL);

  always_ff @(posedge CLK or negedge NGRST) begin
    if (!NGRST) begin
      state <= ST_IDLE;
    end else if (RST) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (bus.TICK && go) state_nxt = ST_ASM;
      ST_ASM:  if (bus.TICK && (k == K_ASM_LAST)) state_nxt = ST_CODE;
      ST_CODE: if (last_tick) state_nxt = go ? ST_ASM : ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge NGRST) begin
    if (!NGRST) begin
      k             <= '0;
      data_frame    <= 1'b0;
      bus.TX_DATA   <= 8'h00;
      bus.TX_VALID  <= 1'b0;
      bus.TX_SOF    <= 1'b0;
      bus.UNDERRUN  <= 1'b0;
      bus.ENC_ERR   <= 1'b0;
      bus.FRAME_CNT <= 16'h0000;
    end else if (RST) begin
      k             <= '0;
      data_frame    <= 1'b0;
      bus.TX_DATA   <= 8'h00;
      bus.TX_VALID  <= 1'b0;
      bus.TX_SOF    <= 1'b0;
      bus.UNDERRUN  <= 1'b0;
      bus.ENC_ERR   <= 1'b0;
      bus.FRAME_CNT <= 16'h0000;
    end else begin
      bus.TX_VALID <= frame_tick;
      bus.TX_SOF   <= frame_tick && (k == 9'd0);
      if (frame_tick) begin
        bus.TX_DATA <= (k < 9'(ASM_LEN)) ? asm_byte(k[1:0]) : bus.ENC_CODE;
        k           <= (k == K_LAST) ? 9'd0 : k + 9'd1;
        if (hs_fault) bus.ENC_ERR <= 1'b1;
      end
      if (decide) data_frame <= bus.SRC_AVAIL;
      if (last_tick) begin
        bus.FRAME_CNT <= bus.FRAME_CNT + 16'd1;
        if (!go) bus.UNDERRUN <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_tm_rsenc_ctrl.sv
// Directed bench for tm_rsenc_ctrl: echo-encoder stub, counting source, and a byte-stream scoreboard.
module tb_tm_rsenc_ctrl;
  localparam int         ENC_LAT = 2;
  localparam logic [7:0] FILL    = 8'h55;
  localparam logic [7:0] XK      = 8'h3C;

  logic CLK = 1'b0;
  logic NGRST = 1'b0;
  logic RST = 1'b0;

  tm_rsenc_ctrl_if bus();

  tm_rsenc_ctrl #(.ENC_LAT(ENC_LAT), .FILL(FILL)) dut (
    .CLK(CLK), .NGRST(NGRST), .RST(RST), .bus(bus)
  );

  initial forever #5 CLK = ~CLK;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // TICK every 4th cycle, driven just after the rising edge
  bit tick_en = 1'b0;
  int ph = 0;
  initial begin
    bus.TICK = 1'b0;
    forever begin
      @(posedge CLK);
      #1;
      ph = (ph + 1) % 4;
      bus.TICK = tick_en && (ph == 0);
    end
  end

  // Source: an endless sequence of bytes i*7+3, head index counts from src_zero
  int src_total = 0;
  int src_zero = 0;
  function automatic logic [7:0] src_byte(input int i);
    return 8'((i * 7 + 3) % 256);
  endfunction
  assign bus.SRC_DATA = src_byte(src_total - src_zero);
  always @(posedge CLK) if (bus.SRC_RD) src_total <= src_total + 1;

  // Encoder stub: codeword byte = byte fed ENC_LAT clock-enables earlier, xor XK
  logic [7:0] dl [0:3];
  always @(posedge CLK or negedge NGRST) begin
    if (!NGRST) begin
      for (int i = 0; i < 4; i++) dl[i] <= 8'h00;
    end else if (bus.ENC_CLKEN) begin
      dl[0] <= bus.ENC_DATA;
      for (int i = 1; i < 4; i++) dl[i] <= dl[i-1];
    end
  end
  assign bus.ENC_CODE = dl[ENC_LAT-1] ^ XK;

  // Expected CADU stream: {sof, byte}
  logic [7:0] asm_b [0:3] = '{8'h1A, 8'hCF, 8'hFC, 8'h1D};
  logic [8:0] exp_q [$];

  task automatic push_frame(input bit data, input int base);
    logic [7:0] b;
    for (int k = 0; k < 259; k++) begin
      if (k < 4)        b = asm_b[k];
      else if (k < 227) b = (data ? src_byte(base + k - 4) : FILL) ^ XK;
      else              b = XK;
      exp_q.push_back({(k == 0), b});
    end
  endtask

  // Compare process
  int cyc = 0;
  int last_vld = 0;
  int sc_bytes = 0;
  int fbytes = 0;
  int sof_cnt = 0;
  int start_pos = -1;
  int start_cnt = 0;
  int sof_at [0:3];
  logic [7:0] cap [0:259];
  logic [8:0] e;

  initial begin
    forever begin
      @(negedge CLK);
      cyc++;
      if (bus.ENC_START === 1'b1) begin
        start_pos = fbytes;
        start_cnt++;
      end
      if (bus.TX_VALID === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_tx_valid", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("tx_data", 32'(bus.TX_DATA), 32'(e[7:0]));
          chk("tx_sof", 32'(bus.TX_SOF), 32'(e[8]));
        end
        if (sc_bytes > 0) chk("tx_gap", 32'(cyc - last_vld), 32'd4);
        last_vld = cyc;
        if (bus.TX_SOF === 1'b1) begin
          if (sof_cnt < 4) sof_at[sof_cnt] = sc_bytes;
          sof_cnt++;
          fbytes = 0;
        end
        if (sc_bytes < 260) cap[sc_bytes] = bus.TX_DATA;
        sc_bytes++;
        fbytes++;
      end
    end
  end

  task automatic clear_books();
    exp_q.delete();
    sc_bytes = 0; fbytes = 0; sof_cnt = 0;
    start_pos = -1; start_cnt = 0;
    src_zero = src_total;
  endtask

  task automatic do_clear();
    @(posedge CLK); #2; RST = 1'b1;
    @(posedge CLK); #2; RST = 1'b0;
    clear_books();
  endtask

  task automatic wait_sof(input int n);
    int t = 0;
    while (sof_cnt < n && t < 6000) begin @(negedge CLK); #1; t++; end
    chk("sof_reached", 32'(sof_cnt >= n), 32'd1);
  endtask

  task automatic wait_bytes(input int n);
    int t = 0;
    while (sc_bytes < n && t < 6000) begin @(negedge CLK); #1; t++; end
    chk("bytes_reached", 32'(sc_bytes >= n), 32'd1);
  endtask

  task automatic wait_drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 6000) begin @(negedge CLK); #1; t++; end
    repeat (40) @(negedge CLK);
    #1;
    chk("drained", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.SRC_AVAIL = 1'b0; bus.IDLE_EN = 1'b0;
    bus.ENC_RFS = 1'b1; bus.ENC_RFD = 1'b1; bus.ENC_RDY = 1'b1;
    repeat (4) @(negedge CLK);
    chk("rst_tx_valid", 32'(bus.TX_VALID), 32'd0);
    chk("rst_tx_sof", 32'(bus.TX_SOF), 32'd0);
    chk("rst_frame_cnt", 32'(bus.FRAME_CNT), 32'd0);
    chk("rst_underrun", 32'(bus.UNDERRUN), 32'd0);
    chk("rst_enc_err", 32'(bus.ENC_ERR), 32'd0);
    chk("rst_src_rd", 32'(bus.SRC_RD), 32'd0);
    chk("rst_enc_start", 32'(bus.ENC_START), 32'd0);
    chk("rst_enc_data", 32'(bus.ENC_DATA), 32'd0);
    @(posedge CLK); #2; NGRST = 1'b1;
    clear_books();
    tick_en = 1'b1;

    // Data frame followed by underrun
    bus.SRC_AVAIL = 1'b1;
    push_frame(1'b1, 0);
    wait_sof(1);
    bus.SRC_AVAIL = 1'b0;
    chk("s1_underrun_mid", 32'(bus.UNDERRUN), 32'd0);
    wait_drain();
    chk("s1_asm0", 32'(cap[0]), 32'h1A);
    chk("s1_asm1", 32'(cap[1]), 32'hCF);
    chk("s1_asm2", 32'(cap[2]), 32'hFC);
    chk("s1_asm3", 32'(cap[3]), 32'h1D);
    chk("s1_code0", 32'(cap[4]), 32'h3F);
    chk("s1_code1", 32'(cap[5]), 32'h36);
    chk("s1_code_last", 32'(cap[258]), 32'h3C);
    chk("s1_len", 32'(sc_bytes), 32'd259);
    chk("s1_src_rd", 32'(src_total - src_zero), 32'd223);
    chk("s1_start_pos", 32'(start_pos), 32'd2);
    chk("s1_start_cnt", 32'(start_cnt), 32'd1);
    chk("s1_frame_cnt", 32'(bus.FRAME_CNT), 32'd1);
    chk("s1_underrun", 32'(bus.UNDERRUN), 32'd1);
    repeat (40) @(negedge CLK);
    #1;
    chk("s1_no_more_tx", 32'(sc_bytes), 32'd259);

    // Idle frame
    do_clear();
    chk("s2_underrun_clr", 32'(bus.UNDERRUN), 32'd0);
    bus.IDLE_EN = 1'b1;
    push_frame(1'b0, 0);
    wait_sof(1);
    bus.IDLE_EN = 1'b0;
    wait_drain();
    chk("s2_fill_first", 32'(cap[4]), 32'h69);
    chk("s2_fill_last", 32'(cap[226]), 32'h69);
    chk("s2_parity0", 32'(cap[227]), 32'h3C);
    chk("s2_src_rd", 32'(src_total - src_zero), 32'd0);
    chk("s2_len", 32'(sc_bytes), 32'd259);
    chk("s2_frame_cnt", 32'(bus.FRAME_CNT), 32'd1);

    // Back-to-back
    do_clear();
    bus.SRC_AVAIL = 1'b1;
    for (int n = 0; n < 3; n++) push_frame(1'b1, 223 * n);
    wait_sof(3);
    bus.SRC_AVAIL = 1'b0;
    wait_drain();
    chk("s3_len", 32'(sc_bytes), 32'd777);
    chk("s3_sof0", 32'(sof_at[0]), 32'd0);
    chk("s3_sof1", 32'(sof_at[1]), 32'd259);
    chk("s3_sof2", 32'(sof_at[2]), 32'd518);
    chk("s3_frame_cnt", 32'(bus.FRAME_CNT), 32'd3);
    chk("s3_src_rd", 32'(src_total - src_zero), 32'd669);

    // Mid-frame asynchronous reset
    do_clear();
    bus.SRC_AVAIL = 1'b1;
    push_frame(1'b1, 0);
    wait_bytes(100);
    NGRST = 1'b0;
    #1;
    chk("s4_tx_valid", 32'(bus.TX_VALID), 32'd0);
    chk("s4_src_rd", 32'(bus.SRC_RD), 32'd0);
    chk("s4_enc_data", 32'(bus.ENC_DATA), 32'd0);
    chk("s4_frame_cnt", 32'(bus.FRAME_CNT), 32'd0);
    exp_q.delete();
    repeat (8) @(negedge CLK);
    clear_books();
    push_frame(1'b1, 0);
    @(posedge CLK); #2; NGRST = 1'b1;
    wait_sof(1);
    bus.SRC_AVAIL = 1'b0;
    wait_drain();
    chk("s4_start_pos", 32'(start_pos), 32'd2);
    chk("s4_start_cnt", 32'(start_cnt), 32'd1);
    chk("s4_len", 32'(sc_bytes), 32'd259);
    chk("s4_src_rd_tot", 32'(src_total - src_zero), 32'd223);
    chk("s4_frame_cnt_end", 32'(bus.FRAME_CNT), 32'd1);

    // Handshake fault: not ready for start
    do_clear();
    chk("s5_err_clr", 32'(bus.ENC_ERR), 32'd0);
    bus.ENC_RFS = 1'b0;
    bus.SRC_AVAIL = 1'b1;
    push_frame(1'b1, 0);
    wait_sof(1);
    bus.SRC_AVAIL = 1'b0;
    wait_drain();
    bus.ENC_RFS = 1'b1;
    chk("s5a_err", 32'(bus.ENC_ERR), 32'd1);
    chk("s5a_len", 32'(sc_bytes), 32'd259);
    chk("s5a_start_cnt", 32'(start_cnt), 32'd1);

    // Handshake fault: output not valid at k=10
    do_clear();
    bus.SRC_AVAIL = 1'b1;
    push_frame(1'b1, 0);
    wait_sof(1);
    bus.SRC_AVAIL = 1'b0;
    wait_bytes(10);
    chk("s5b_err_before", 32'(bus.ENC_ERR), 32'd0);
    bus.ENC_RDY = 1'b0;
    wait_bytes(11);
    bus.ENC_RDY = 1'b1;
    chk("s5b_err_set", 32'(bus.ENC_ERR), 32'd1);
    wait_drain();
    chk("s5b_err_sticky", 32'(bus.ENC_ERR), 32'd1);
    chk("s5b_len", 32'(sc_bytes), 32'd259);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
